// File: rtl/vector_ls_seq_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vector_ls_seq_pkg : shared types and helpers for the vector LS sequencer   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package vector_ls_seq_pkg;

  localparam int VLS_MAX_ADDR_W  = 64;
  localparam int VLS_MAX_SLICE_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_REQ = 3'd1,
    S_LD_WR  = 3'd2,
    S_ST_CAP = 3'd3,
    S_ST_REQ = 3'd4
  } vls_state_e;

  // Widest supported command; the sequencer zero-extends its ports into it.
  typedef struct packed {
    logic                       store;
    logic [VLS_MAX_SLICE_W-1:0] slice;
    logic [VLS_MAX_ADDR_W-1:0]  addr;
    logic [VLS_MAX_ADDR_W-1:0]  stride;
  } Vls_cmd;

  function automatic int vls_num_words(input int num_elems, input int elem_size,
                                       input int scalar_size);
    return (num_elems * elem_size) / scalar_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vls_addr_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vls_addr_gen : latches base/stride on accept, forms base + word*stride     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module vls_addr_gen
  import vector_ls_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic [ADDR_WIDTH-1:0] stride_in,
  input  logic [WORD_W-1:0]     word,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;

  always_comb begin
    base_d   = base_q;
    stride_d = stride_q;
    if (load) begin
      base_d   = base_in;
      stride_d = stride_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q   <= '0;
      stride_q <= '0;
    end else begin
      base_q   <= base_d;
      stride_q <= stride_d;
    end
  end

  // Truncation to ADDR_WIDTH gives the silent wrap-around.
  assign addr = base_q + ADDR_WIDTH'(word) * stride_q;

endmodule
`default_nettype wire

// File: rtl/vector_ls_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vector_ls_seq : memory-side load/store sequencer for vector slices         |
// | Option: VECTOR_LS_SEQ_STRIDE_EN adds a per-command byte stride port.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module vector_ls_seq
  import vector_ls_seq_pkg::*;
#(
  parameter int NUM_SLICES  = 4,
  parameter int NUM_ELEMS   = 8,
  parameter int ELEM_SIZE   = 16,
  parameter int SCALAR_SIZE = 32,
  parameter int ADDR_WIDTH  = 32,
  localparam int NUM_WORDS  = vls_num_words(NUM_ELEMS, ELEM_SIZE, SCALAR_SIZE),
  localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
  localparam int WORD_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_store,
  input  logic [SLICE_W-1:0]     cmd_slice,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
`ifdef VECTOR_LS_SEQ_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]  cmd_stride,
`endif
  output logic                   done,
  output logic [NUM_SLICES-1:0]  load_en,
  output logic [WORD_W-1:0]      sel_word,
  output logic [SCALAR_SIZE-1:0] load_data,
  output logic                   store_en,
  output logic [NUM_SLICES-1:0]  serial_output,
  output logic [WORD_W-1:0]      sel_store_word,
  input  logic [SCALAR_SIZE-1:0] store_serial_in,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [SCALAR_SIZE-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [SCALAR_SIZE-1:0] mem_rdata
);

  localparam logic [WORD_W-1:0] W_LAST = WORD_W'(NUM_WORDS - 1);

  vls_state_e               state_q, state_d;
  logic [WORD_W-1:0]        w_q, w_d;
  logic [SLICE_W-1:0]       slice_q, slice_d;
  logic                     done_q, done_d;
  logic [SCALAR_SIZE-1:0]   load_data_q, load_data_d;

  Vls_cmd                   cmd_in;
  logic                     unused_cmd_bits;
  logic                     slice_ok;
  logic                     accept;
  logic                     ld_wr;
  logic                     st_req;
  logic [ADDR_WIDTH-1:0]    gen_addr;

  always_comb begin
    cmd_in.store  = cmd_store;
    cmd_in.slice  = VLS_MAX_SLICE_W'(cmd_slice);
    cmd_in.addr   = VLS_MAX_ADDR_W'(cmd_addr);
`ifdef VECTOR_LS_SEQ_STRIDE_EN
    cmd_in.stride = VLS_MAX_ADDR_W'(cmd_stride);
`else
    cmd_in.stride = VLS_MAX_ADDR_W'(SCALAR_SIZE / 8);
`endif
  end

  assign unused_cmd_bits = ^cmd_in;
  assign slice_ok        = (cmd_in.slice < VLS_MAX_SLICE_W'(NUM_SLICES));
  assign accept          = cmd_valid && (state_q == S_IDLE) && slice_ok;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    slice_d     = slice_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    cmd_ready   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    store_en    = 1'b0;
    ld_wr       = 1'b0;
    st_req      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (slice_ok) begin
            slice_d = cmd_in.slice[SLICE_W-1:0];
            w_d     = '0;
            state_d = cmd_in.store ? S_ST_CAP : S_LD_REQ;
          end else begin
            // Out-of-range slice: swallow the command and just report completion.
            done_d = 1'b1;
          end
        end
      end
      S_LD_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          load_data_d = mem_rdata;
          state_d     = S_LD_WR;
        end
      end
      S_LD_WR: begin
        ld_wr = 1'b1;
        if (w_q == W_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          w_d     = w_q + 1'b1;
          state_d = S_LD_REQ;
        end
      end
      S_ST_CAP: begin
        store_en = 1'b1;
        state_d  = S_ST_REQ;
      end
      S_ST_REQ: begin
        st_req  = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          if (w_q == W_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      slice_q     <= '0;
      done_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      slice_q     <= slice_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
    end
  end

  vls_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_W     (WORD_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .base_in   (cmd_in.addr[ADDR_WIDTH-1:0]),
    .stride_in (cmd_in.stride[ADDR_WIDTH-1:0]),
    .word      (w_q),
    .addr      (gen_addr)
  );

  for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice_sel
    assign load_en[s]       = ld_wr && (slice_q == SLICE_W'(s));
    assign serial_output[s] = st_req && (slice_q == SLICE_W'(s));
  end

  assign done           = done_q;
  assign load_data      = load_data_q;
  assign sel_word       = w_q;
  assign sel_store_word = w_q;
  assign mem_addr       = mem_req ? gen_addr : '0;
  assign mem_wdata      = st_req ? store_serial_in : '0;

endmodule
`default_nettype wire

// File: tb/tb_vector_ls_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized self-checking bench for vector_ls_seq against a transaction-level model.
module tb_vector_ls_seq;

  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid, cmd_store, cmd_ready, done;
  logic [1:0]  cmd_slice;
  logic [31:0] cmd_addr, cmd_stride;
  logic [3:0]  load_en, serial_output;
  logic [1:0]  sel_word, sel_store_word;
  logic [31:0] load_data, store_serial_in, mem_addr, mem_wdata, mem_rdata;
  logic        store_en, mem_req, mem_we, mem_ack;
  logic [31:0] chain_base;

  logic        cmd_valid3, cmd_ready3, done3, store_en3, mem_req3, mem_we3;
  logic [1:0]  cmd_slice3, sel_word3, sel_store_word3;
  logic [2:0]  load_en3, serial_output3;
  logic [31:0] load_data3, mem_addr3, mem_wdata3;

  int n_tests = 0;
  int n_fail  = 0;

  // Slice chain model: word k of the captured vector is chain_base + k.
  assign store_serial_in = chain_base + 32'(sel_store_word);

  vector_ls_seq u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_store(cmd_store), .cmd_slice(cmd_slice), .cmd_addr(cmd_addr),
`ifdef VECTOR_LS_SEQ_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .done(done), .load_en(load_en), .sel_word(sel_word), .load_data(load_data),
    .store_en(store_en), .serial_output(serial_output), .sel_store_word(sel_store_word),
    .store_serial_in(store_serial_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  vector_ls_seq #(.NUM_SLICES(3)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_store(cmd_store), .cmd_slice(cmd_slice3), .cmd_addr(cmd_addr),
`ifdef VECTOR_LS_SEQ_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .done(done3), .load_en(load_en3), .sel_word(sel_word3), .load_data(load_data3),
    .store_en(store_en3), .serial_output(serial_output3), .sel_store_word(sel_store_word3),
    .store_serial_in(32'h0), .mem_req(mem_req3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_ack(1'b1), .mem_rdata(32'h5)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_load_en"}, load_en, 0);
    check({tag, "_sel_word"}, sel_word, 0);
    check({tag, "_load_data"}, load_data, 0);
    check({tag, "_store_en"}, store_en, 0);
    check({tag, "_serial_output"}, serial_output, 0);
    check({tag, "_sel_store_word"}, sel_store_word, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Issues one command in the current cycle, plays the memory, checks every event.
  task automatic run_cmd(input bit st, input int sl, input logic [31:0] addr,
                         input int fixed_wait, input bit rnd);
    logic [31:0] rd [NW];
    int          wt [NW];
    int          exp_done, k, nwr, lc, sc, wl, done_c;
    bit          in_req;
    logic [31:0] exp_a;
    for (int i = 0; i < NW; i++) begin
      rd[i] = rnd ? $urandom : 32'hA0 + i;
      wt[i] = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
    end
    exp_done = st ? 2 : 1;
    for (int i = 0; i < NW; i++) exp_done += st ? (1 + wt[i]) : (2 + wt[i]);

    check("cmd_ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_store = st;
    cmd_slice = 2'(sl);
    cmd_addr  = addr;
    tick;
    cmd_valid = 1'b0;

    k = 0; nwr = 0; lc = 0; sc = 0; wl = 0; in_req = 1'b0; done_c = -1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        done_c = c;
        break;
      end
      if (load_en != 0) begin
        lc++;
        check("load_en", load_en, 4'b1 << sl);
        check("sel_word", sel_word, nwr);
        if (nwr < NW) check("load_data", load_data, rd[nwr]);
        nwr++;
      end
      if (store_en) begin
        sc++;
        check("store_en_cycle", c, 1);
      end
      check("serial_output", serial_output, (mem_req && mem_we) ? (4'b1 << sl) : 4'b0);
      mem_ack   = 1'b0;
      mem_rdata = rnd ? $urandom : 32'h0;
      if (mem_req) begin
        exp_a = addr + 32'(k) * cmd_stride;
        check("mem_addr", mem_addr, exp_a);
        check("mem_we", mem_we, st);
        check("mem_wdata", mem_wdata, st ? chain_base + 32'(k) : 32'h0);
        if (!in_req) begin
          in_req = 1'b1;
          wl     = (k < NW) ? wt[k] : 0;
        end
        if (wl == 0) begin
          mem_ack = 1'b1;
          if (!st && k < NW) mem_rdata = rd[k];
          k++;
          in_req = 1'b0;
        end else begin
          wl--;
        end
      end else if (rnd) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      tick;
    end
    mem_ack = 1'b0;
    if (done_c < 0) check("done_timeout", 0, 1);
    else            check("done_cycle", done_c, exp_done);
    check("ack_count", k, NW);
    check("load_en_count", lc, st ? 0 : NW);
    check("store_en_count", sc, st ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
    cmd_store  = 1'b0;
    cmd_slice  = '0;
    cmd_slice3 = '0;
    cmd_addr   = '0;
    cmd_stride = 32'd4;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    chain_base = '0;
    repeat (3) tick;
    check_reset("por");
    reset = 1'b1;
    tick;
    check_reset("post_reset");

    // Out-of-range slice on the 3-slice instance, then a back-to-back load.
    cmd_valid3 = 1'b1; cmd_slice3 = 2'd3; cmd_store = 1'b0; cmd_addr = 32'h400;
    tick;
    cmd_slice3 = 2'd0;
    check("inv_done", done3, 1);
    check("inv_ready", cmd_ready3, 1);
    check("inv_mem_req", mem_req3, 0);
    check("inv_strobes", {load_en3, store_en3, serial_output3, mem_we3}, 0);
    check("inv_data", {load_data3, mem_wdata3, mem_addr3}, 0);
    check("inv_word_idx", {sel_word3, sel_store_word3}, 0);
    tick;
    cmd_valid3 = 1'b0;
    check("b2b_done_low", done3, 0);
    check("b2b_mem_req", mem_req3, 1);
    check("b2b_mem_addr", mem_addr3, 32'h400);
    cyc = -1;
    for (int c = 1; c <= 50; c++) begin
      if (done3) begin cyc = c; break; end
      tick;
    end
    check("b2b_done_cycle", cyc, 9);

    // Directed cases; each command is offered in the previous one's done cycle.
    run_cmd(1'b0, 2, 32'h0000_0100, 0, 1'b0);
    chain_base = 32'hB0;
    run_cmd(1'b1, 1, 32'h0000_0200, 0, 1'b0);
    run_cmd(1'b0, 0, 32'h0000_1000, 3, 1'b0);
    run_cmd(1'b0, 3, 32'hFFFF_FFFC, 0, 1'b0);

    // Reset during the second word write of a load.
    mem_ack = 1'b1; mem_rdata = 32'h77;
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_slice = 2'd3; cmd_addr = 32'h300;
    tick;
    cmd_valid = 1'b0;
    repeat (3) tick;
    check("abort_load_en", load_en, 4'b1000);
    check("abort_sel_word", sel_word, 1);
    reset = 1'b0;
    tick;
    check_reset("abort");
    reset = 1'b1; mem_ack = 1'b0;
    tick;
    check("abort_no_done", done, 0);
    run_cmd(1'b0, 1, 32'h0000_0500, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      chain_base = $urandom;
`ifdef VECTOR_LS_SEQ_STRIDE_EN
      cmd_stride = $urandom_range(0, 64);
`endif
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
